// File: rtl/key_bank_if.sv
// key_bank_if: loader/cipher-side signal bundle for key_bank.
// The master drives the loader strobes.
// The slave (key_bank) returns the bank contents and status.
interface key_bank_if #(
  parameter int KEY_W    = 8,
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = $clog2(NUM_KEYS + 1),
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
  logic [KEY_W-1:0]          din;
  logic                      kset;
  logic                      klock;
  logic                      knext;
  logic [CNT_W-1:0]          num_keys;
  logic [KEY_W*NUM_KEYS-1:0] keys;
  logic [KEY_W-1:0]          key_out;
  logic [IDX_W-1:0]          key_idx;
  logic                      full;
  logic                      locked;
  logic                      err;

  modport master (
    output din, kset, klock, knext,
    input  num_keys, keys, key_out, key_idx, full, locked, err
  );

  modport slave (
    input  din, kset, klock, knext,
    output num_keys, keys, key_out, key_idx, full, locked, err
  );
endinterface

// File: rtl/key_bank.sv
// key_bank: parametrised key store.
// Keys are loaded one per kset and the bank is then locked with klock.
// While locked, knext steps the read index round-robin over the loaded keys.
module key_bank #(
  parameter int KEY_W    = 8,
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = $clog2(NUM_KEYS + 1),
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input logic       dclk,
  input logic       reset,
  key_bank_if.slave bus
);
  typedef enum logic {ST_LOAD = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                           r_state;
  state_t                           w_state_next;
  logic [NUM_KEYS-1:0][KEY_W-1:0]   r_slots;
  logic [CNT_W-1:0]                 r_num_keys;
  logic [CNT_W-1:0]                 w_num_keys_next;
  logic [IDX_W-1:0]                 r_key_idx;
  logic [IDX_W-1:0]                 w_key_idx_next;
  logic                             r_err;
  logic                             w_err_next;
  logic                             w_full;
  logic                             w_wr_en;
  logic                             w_lock_ok;
  logic [NUM_KEYS-1:0]              w_slot_we;
  logic [KEY_W-1:0]                 w_key_out;

  assign w_full  = (r_num_keys == CNT_W'(NUM_KEYS));
  assign w_wr_en = (r_state == ST_LOAD) && bus.kset && !w_full;
  // A same-cycle write counts toward the lock, so one fresh key is enough.
  assign w_lock_ok = (r_state == ST_LOAD) && bus.klock &&
                     (w_wr_en || (r_num_keys != '0));

  // Per-slot write enables: the next free slot is the one at num_keys.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_we
      assign w_slot_we[gi] = w_wr_en && (r_num_keys == CNT_W'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge dclk) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_state_next;
  end

  // Next state, count, read index and sticky error.
  always_comb begin
    w_state_next    = r_state;
    w_num_keys_next = r_num_keys;
    w_key_idx_next  = r_key_idx;
    w_err_next      = r_err;
    case (r_state)
      ST_LOAD: begin
        if (w_wr_en) w_num_keys_next = r_num_keys + CNT_W'(1);
        if (bus.kset && w_full) w_err_next = 1'b1;
        if (w_lock_ok) begin
          w_state_next   = ST_LOCKED;
          w_key_idx_next = '0;
        end
      end
      ST_LOCKED: begin
        if (bus.kset) w_err_next = 1'b1;
        // Wrap at the loaded count, not at the slot capacity.
        if (bus.knext) begin
          if (CNT_W'(r_key_idx) == (r_num_keys - CNT_W'(1)))
            w_key_idx_next = '0;
          else
            w_key_idx_next = r_key_idx + IDX_W'(1);
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  // Count, index and error registers.
  always_ff @(posedge dclk) begin
    if (reset) begin
      r_num_keys <= '0;
      r_key_idx  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_num_keys <= w_num_keys_next;
      r_key_idx  <= w_key_idx_next;
      r_err      <= w_err_next;
    end
  end

  // Slot storage; unwritten slots keep their reset value of zero.
  always_ff @(posedge dclk) begin
    if (reset) begin
      r_slots <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_slot_we[i]) r_slots[i] <= bus.din;
      end
    end
  end

  // Read mux selecting the slot at the current index.
  always_comb begin
    w_key_out = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (r_key_idx == IDX_W'(i)) w_key_out = r_slots[i];
    end
  end

  assign bus.keys     = r_slots;
  assign bus.num_keys = r_num_keys;
  assign bus.key_idx  = r_key_idx;
  assign bus.key_out  = w_key_out;
  assign bus.full     = w_full;
  assign bus.locked   = (r_state == ST_LOCKED);
  assign bus.err      = r_err;
endmodule

// File: doc/key_bank.md
# key_bank

Parametrised key storage bank that replaces the fixed 4×8-bit key register. The loader streams key bytes in one per `kset` strobe; a `klock` strobe then locks the bank. While locked, the cipher datapath steps through the stored keys round-robin with `knext`. The block adds full, locked and sticky-error status, and sits between the byte loader and the encrypt/decrypt core.

## Interface
Parameters:
- `KEY_W`, default 8: width of one key slot in bits.
- `NUM_KEYS`, default 4: number of slots; legal range 1–16.
- `CNT_W`, default `$clog2(NUM_KEYS+1)`: width of the key count.
- `IDX_W`, default `max(1,$clog2(NUM_KEYS))`: width of the read index.

Ports:
- `dclk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  KEY_W  key data, sampled when `kset`=1.
- `kset`  in  1  write strobe; stores `din` into the next free slot.
- `klock`  in  1  lock strobe; ends loading.
- `knext`  in  1  advance the read index (locked state only).
- `num_keys`  out  CNT_W  number of slots written, 0..NUM_KEYS.
- `keys`  out  KEY_W*NUM_KEYS  all slots, packed; slot 0 in the LSBs.
- `key_out`  out  KEY_W  contents of slot `key_idx` (combinational from registers).
- `key_idx`  out  IDX_W  current read index.
- `full`  out  1  `num_keys`==NUM_KEYS.
- `locked`  out  1  state==LOCKED.
- `err`  out  1  sticky illegal-write flag.

## Operation
- State machine has two states: LOAD and LOCKED.
- Reset takes priority over every other input. It sets LOAD, all slots=0, `num_keys`=0, `key_idx`=0 and `err`=0, which makes `full`=0, `locked`=0 and `key_out`=0.
- LOAD, `kset`=1, not full: slot[`num_keys`] ← `din`; `num_keys` +1.
- LOAD, `kset`=1, full: write is dropped; `err` ← 1; `num_keys` holds.
- LOAD, `klock`=1, effective count after this cycle's write ≥1: go to LOCKED and set `key_idx`=0.
- LOAD, `klock`=1, count 0 with no write this cycle: ignored; stay in LOAD. `err` is unchanged.
- `kset` and `klock` in the same LOAD cycle: the write is applied first, then the lock. `num_keys` includes the new key, and that single key is enough to satisfy the lock.
- LOAD: `knext` is ignored; `key_idx` stays 0.
- LOCKED: `kset`=1 is dropped and sets `err` ← 1. Slots and `num_keys` are frozen.
- LOCKED: `klock` is ignored.
- LOCKED, `knext`=1: `key_idx` ← (`key_idx`==`num_keys`−1) ? 0 : `key_idx`+1. Wrap is at the loaded count, not at NUM_KEYS.
- LOCKED with `num_keys`=1: `knext` leaves `key_idx` at 0.
- LOCKED is left only by `reset`. `err` is cleared only by `reset`.
- Unwritten slots read 0.
- `full` and `locked` are decoded from registered state; there are no combinational paths from inputs to outputs.

## Timing
- Writes: `keys`, `num_keys` and `full` update one cycle after the `kset` edge. Back-to-back `kset` on consecutive cycles is supported, one slot per cycle.
- Lock: `locked`=1 on the cycle after the accepted `klock`. `key_out` equals slot 0 on that same cycle.
- Read stepping: `key_idx` and `key_out` change one cycle after `knext`. A `knext` held high steps one slot per cycle.
- Error flag: `err` rises one cycle after the offending `kset`.
- Reset: a `reset` asserted mid-load or while locked wins over any simultaneous `kset`/`klock`/`knext`. All outputs read their reset values on the next cycle.

## Test plan
- Reset, then `kset` with `din`=0x11,0x22,0x33,0x44 on consecutive cycles (defaults) → `keys`=0x44332211, `num_keys`=4, `full`=1, `err`=0.
- Fifth `kset` with `din`=0x55 → `keys` unchanged, `err`=1. `err` stays 1 until `reset`.
- Load 0xA1,0xB2,0xC3, then `klock` → `locked`=1, `key_out`=0xA1. Four `knext` pulses → `key_out`=0xB2,0xC3,0xA1,0xB2 (wrap at 3).
- `klock` with 0 keys → `locked` stays 0. A `kset`(0x7E) and `klock` in the same cycle → `num_keys`=1, `locked`=1, `key_out`=0x7E; `knext` keeps `key_idx`=0.
- LOCKED with 2 keys, `kset` with `din`=0xFF → slots unchanged, `err`=1. Then `reset` together with `knext` → all outputs 0 and state LOAD next cycle.
- NUM_KEYS=16, KEY_W=16: load 16 words 0x0000..0x000F, lock, 16 `knext` pulses → `key_idx` returns to 0, `key_out`=0x0000.
